// File: rtl/multiphase_sine_dds_if.sv
// Configuration channel of the multiphase sine DDS: a new tuning word and
// amplitude offered to the generator.
interface multiphase_sine_dds_if #(
    parameter int ACC_W = 16,
    parameter int AMP_W = 8
);
    // A transfer happens on a rising clk edge where cfg_valid and cfg_ready are
    // both 1. The master holds cfg_ftw/cfg_amp stable while cfg_valid is 1, and
    // cfg_ready never depends on cfg_valid.
    logic             cfg_valid;
    logic             cfg_ready;
    logic [ACC_W-1:0] cfg_ftw;
    logic [AMP_W-1:0] cfg_amp;

    modport master (output cfg_valid, output cfg_ftw, output cfg_amp, input cfg_ready);
    modport slave  (input cfg_valid, input cfg_ftw, input cfg_amp, output cfg_ready);
endinterface

// File: rtl/multiphase_sine_dds.sv
// N_CH-phase sine generator: one phase accumulator, channels offset by 1/N_CH
// of a turn, full-wave sine ROM, amplitude scaling, two-stage output pipeline.
module multiphase_sine_dds #(
    parameter int N_CH   = 3,
    parameter int OUT_W  = 8,
    parameter int ACC_W  = 16,
    parameter int LUT_AW = 8,
    parameter int AMP_W  = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    multiphase_sine_dds_if.slave   cfg,
    output logic [N_CH*OUT_W-1:0]  out_data,
    output logic                   out_valid,
    output logic                   sync,
    output logic [1:0]             dbg_state
);
    localparam int LUT_N = 1 << LUT_AW;
    localparam int PW    = OUT_W + AMP_W + 2;
    localparam logic [OUT_W-1:0] MID = OUT_W'(1) << (OUT_W - 1);
    localparam longint unsigned PHASE_STEP = (64'd1 << ACC_W) / N_CH;
    localparam real PI = 3.14159265358979323846;

    // dbg_state encoding: 0 = STOP, 1 = RUN, 2 = PEND
    typedef enum logic [1:0] {
        ST_STOP = 2'd0,
        ST_RUN  = 2'd1,
        ST_PEND = 2'd2
    } state_t;

    function automatic logic [OUT_W-1:0] lut_entry(input int k);
        real r;
        r = (2.0 ** (OUT_W - 1) - 1.0) * $sin(2.0 * PI * k / LUT_N);
        return OUT_W'(int'(r) + int'(MID));
    endfunction

    logic [OUT_W-1:0] lut_rom [LUT_N];
    for (genvar k = 0; k < LUT_N; k++) begin : g_rom
        assign lut_rom[k] = lut_entry(k);
    end

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [ACC_W-1:0]   ftw_q, ftw_d;
    logic [ACC_W-1:0]   sh_ftw_q, sh_ftw_d;
    logic [AMP_W-1:0]   amp_q, amp_d;
    logic [AMP_W-1:0]   sh_amp_q, sh_amp_d;
    logic               sync0_q, sync0_d;
    logic [ACC_W:0]     acc_sum;
    logic               cfg_fire;

    logic [OUT_W-1:0]   lut1_q [N_CH];
    logic [OUT_W-1:0]   lut1_d [N_CH];
    logic [AMP_W-1:0]   amp1_q, amp1_d;
    logic               valid1_q, valid1_d, sync1_q, sync1_d;
    logic signed [PW-1:0] prod [N_CH];
    logic [N_CH*OUT_W-1:0] data2_q, data2_d;
    logic               valid2_q, valid2_d, sync2_q, sync2_d;

    assign cfg.cfg_ready = (state_q != ST_PEND);
    assign cfg_fire      = cfg.cfg_valid && (state_q != ST_PEND);
    assign acc_sum       = {1'b0, acc_q} + {1'b0, ftw_q};

    // sync0 marks the stage-0 sample that is first after a wrap or after leaving STOP
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        ftw_d    = ftw_q;
        amp_d    = amp_q;
        sh_ftw_d = sh_ftw_q;
        sh_amp_d = sh_amp_q;
        sync0_d  = 1'b0;
        case (state_q)
            ST_STOP: begin
                acc_d = '0;
                if (cfg_fire) begin
                    ftw_d = cfg.cfg_ftw;
                    amp_d = cfg.cfg_amp;
                end
                if (en) begin
                    state_d = ST_RUN;
                    sync0_d = 1'b1;
                end
            end
            ST_RUN: begin
                if (!en) begin
                    state_d = ST_STOP;
                    acc_d   = '0;
                    if (cfg_fire) begin
                        ftw_d = cfg.cfg_ftw;
                        amp_d = cfg.cfg_amp;
                    end
                end else begin
                    acc_d   = acc_sum[ACC_W-1:0];
                    sync0_d = acc_sum[ACC_W];
                    if (cfg_fire) begin
                        sh_ftw_d = cfg.cfg_ftw;
                        sh_amp_d = cfg.cfg_amp;
                        state_d  = ST_PEND;
                    end
                end
            end
            ST_PEND: begin
                if (!en) begin
                    state_d = ST_STOP;
                    acc_d   = '0;
                    ftw_d   = sh_ftw_q;
                    amp_d   = sh_amp_q;
                end else begin
                    acc_d   = acc_sum[ACC_W-1:0];
                    sync0_d = acc_sum[ACC_W];
                    if (acc_sum[ACC_W]) begin
                        ftw_d   = sh_ftw_q;
                        amp_d   = sh_amp_q;
                        state_d = ST_RUN;
                    end
                end
            end
            default: begin
                state_d = ST_STOP;
                acc_d   = '0;
            end
        endcase
    end

    // Stage 1: ROM read per channel; the amplitude travels with its sample
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            lut1_d[i] = lut_rom[LUT_AW'((acc_q + ACC_W'(PHASE_STEP * i)) >> (ACC_W - LUT_AW))];
        end
        amp1_d   = amp_q;
        valid1_d = (state_q != ST_STOP);
        sync1_d  = sync0_q;
    end

    // Stage 2: y = mid + floor((lut - mid) * amp / 2^AMP_W), mid while invalid
    always_comb begin
        data2_d = '0;
        for (int i = 0; i < N_CH; i++) begin
            prod[i] = (PW'($signed({1'b0, lut1_q[i]})) - PW'($signed({1'b0, MID})))
                      * PW'($signed({1'b0, amp1_q}));
            data2_d[i*OUT_W +: OUT_W] = valid1_q ? MID + OUT_W'(prod[i] >>> AMP_W) : MID;
        end
        valid2_d = valid1_q;
        sync2_d  = sync1_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_STOP;
            acc_q    <= '0;
            ftw_q    <= '0;
            amp_q    <= '1;
            sh_ftw_q <= '0;
            sh_amp_q <= '0;
            sync0_q  <= 1'b0;
            for (int i = 0; i < N_CH; i++) lut1_q[i] <= MID;
            amp1_q   <= '1;
            valid1_q <= 1'b0;
            sync1_q  <= 1'b0;
            data2_q  <= {N_CH{MID}};
            valid2_q <= 1'b0;
            sync2_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            ftw_q    <= ftw_d;
            amp_q    <= amp_d;
            sh_ftw_q <= sh_ftw_d;
            sh_amp_q <= sh_amp_d;
            sync0_q  <= sync0_d;
            for (int i = 0; i < N_CH; i++) lut1_q[i] <= lut1_d[i];
            amp1_q   <= amp1_d;
            valid1_q <= valid1_d;
            sync1_q  <= sync1_d;
            data2_q  <= data2_d;
            valid2_q <= valid2_d;
            sync2_q  <= sync2_d;
        end
    end

    assign out_data  = data2_q;
    assign out_valid = valid2_q;
    assign sync      = sync2_q;
    assign dbg_state = state_q;
endmodule

// File: tb/tb_multiphase_sine_dds.sv
// Bench for multiphase_sine_dds: scenario tasks plus random traffic, scored
// against a cycle-level reference model of the generator's rules.
module tb_multiphase_sine_dds;
    localparam int N_CH   = 3;
    localparam int OUT_W  = 8;
    localparam int ACC_W  = 16;
    localparam int LUT_AW = 8;
    localparam int AMP_W  = 8;
    localparam int DW     = N_CH * OUT_W;
    localparam int W      = DW + 2;
    localparam longint M    = longint'(1) << ACC_W;
    localparam longint STEP = M / N_CH;
    localparam int MID      = 1 << (OUT_W - 1);
    localparam real PI      = 3.14159265358979323846;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          sync;
    logic [1:0]    dbg_state;
    logic [DW-1:0] mid_all;

    multiphase_sine_dds_if #(.ACC_W(ACC_W), .AMP_W(AMP_W)) cfg_if ();

    multiphase_sine_dds #(
        .N_CH(N_CH), .OUT_W(OUT_W), .ACC_W(ACC_W), .LUT_AW(LUT_AW), .AMP_W(AMP_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .cfg       (cfg_if.slave),
        .out_data  (out_data),
        .out_valid (out_valid),
        .sync      (sync),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    logic [W-1:0] exp_q[$];

    // Reference model state: what the generator holds after each edge
    bit     m_run, m_sync, m_pend;
    longint m_acc;
    int     m_ftw, m_amp, m_sh_ftw, m_sh_amp;

    function automatic int lut_ref(input int k);
        real r;
        r = 127.0 * $sin(2.0 * PI * k / 256.0);
        return int'(r) + MID;
    endfunction

    function automatic int scale_ref(input int lutv, input int amp);
        int p;
        p = (lutv - MID) * amp;
        if (p >= 0) return MID + p / 256;
        return MID - ((-p + 255) / 256);
    endfunction

    function automatic logic [W-1:0] sample_ref();
        logic [DW-1:0] d;
        longint ph;
        d = mid_all;
        if (m_run) begin
            for (int i = 0; i < N_CH; i++) begin
                ph = (m_acc + i * STEP) % M;
                d[i*OUT_W +: OUT_W] = OUT_W'(scale_ref(lut_ref(int'(ph / (M / 256))), m_amp));
            end
        end
        return {m_run, m_run & m_sync, d};
    endfunction

    task automatic model_reset();
        m_run = 0; m_sync = 0; m_pend = 0; m_acc = 0;
        m_ftw = 0; m_amp = (1 << AMP_W) - 1; m_sh_ftw = 0; m_sh_amp = 0;
        exp_q.delete();
        exp_q.push_back({2'b00, mid_all});
        exp_q.push_back({2'b00, mid_all});
    endtask

    task automatic model_step(input bit e, input bit cv, input int f, input int a);
        bit     take;
        longint nxt;
        take   = cv && !m_pend;
        m_sync = 0;
        if (!m_run) begin
            if (take) begin m_ftw = f; m_amp = a; end
            m_acc = 0;
            if (e) begin m_run = 1; m_sync = 1; end
        end else if (!e) begin
            m_run = 0;
            m_acc = 0;
            if (m_pend) begin m_ftw = m_sh_ftw; m_amp = m_sh_amp; m_pend = 0; end
            if (take) begin m_ftw = f; m_amp = a; end
        end else begin
            nxt    = m_acc + m_ftw;
            m_sync = (nxt >= M);
            m_acc  = nxt % M;
            if (m_pend && m_sync) begin
                m_ftw = m_sh_ftw; m_amp = m_sh_amp; m_pend = 0;
            end else if (take) begin
                m_sh_ftw = f; m_sh_amp = a; m_pend = 1;
            end
        end
    endtask

    // Drive one cycle, advance the model and score the outputs against it
    task automatic cycle(input bit e, input bit cv, input int f, input int a);
        logic [W-1:0] exp;
        logic         exp_rdy;
        en               = e;
        cfg_if.cfg_valid = cv;
        cfg_if.cfg_ftw   = ACC_W'(f);
        cfg_if.cfg_amp   = AMP_W'(a);
        @(posedge clk);
        #1;
        model_step(e, cv, f, a);
        exp_q.push_back(sample_ref());
        exp     = exp_q.pop_front();
        exp_rdy = !m_pend;
        n_checks += 4;
        if (out_data !== exp[DW-1:0]) begin
            n_errors++;
            $display("FAIL out_data @%0t: got %h expected %h", $time, out_data, exp[DW-1:0]);
        end
        if (out_valid !== exp[W-1]) begin
            n_errors++;
            $display("FAIL out_valid @%0t: got %b expected %b", $time, out_valid, exp[W-1]);
        end
        if (sync !== exp[W-2]) begin
            n_errors++;
            $display("FAIL sync @%0t: got %b expected %b", $time, sync, exp[W-2]);
        end
        if (cfg_if.cfg_ready !== exp_rdy) begin
            n_errors++;
            $display("FAIL cfg_ready @%0t: got %b expected %b", $time, cfg_if.cfg_ready, exp_rdy);
        end
    endtask

    task automatic test_reset();
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_ftw   = '0;
        cfg_if.cfg_amp   = '0;
        #22 rst_n = 1'b1;
        #1;
        n_checks += 5;
        if (out_data !== mid_all) begin n_errors++; $display("FAIL reset_data: got %h expected %h", out_data, mid_all); end
        if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
        if (sync !== 1'b0) begin n_errors++; $display("FAIL reset_sync: got %b expected 0", sync); end
        if (cfg_if.cfg_ready !== 1'b1) begin n_errors++; $display("FAIL reset_ready: got %b expected 1", cfg_if.cfg_ready); end
        if (dbg_state !== 2'd0) begin n_errors++; $display("FAIL reset_state: got %0d expected 0", dbg_state); end
        model_reset();
    endtask

    task automatic test_basic();
        logic [OUT_W-1:0] ch0 [10];
        logic             sy [10];
        logic             vl [10];
        cycle(0, 1, 'h4000, 'hFF);
        for (int j = 0; j < 10; j++) begin
            cycle(1, 0, 0, 0);
            ch0[j] = out_data[OUT_W-1:0];
            sy[j]  = sync;
            vl[j]  = out_valid;
        end
        n_checks += 8;
        if (vl[0] !== 1'b0 || vl[1] !== 1'b0) begin n_errors++; $display("FAIL basic_latency: got %b%b expected 00", vl[0], vl[1]); end
        if (vl[2] !== 1'b1) begin n_errors++; $display("FAIL basic_valid_rise: got %b expected 1", vl[2]); end
        if (ch0[2] !== 8'h80 || sy[2] !== 1'b1) begin n_errors++; $display("FAIL basic_k0: got %h/%b expected 80/1", ch0[2], sy[2]); end
        if (ch0[3] !== 8'hFE) begin n_errors++; $display("FAIL basic_k64: got %h expected fe", ch0[3]); end
        if (ch0[4] !== 8'h80 || sy[4] !== 1'b0) begin n_errors++; $display("FAIL basic_k128: got %h/%b expected 80/0", ch0[4], sy[4]); end
        if (ch0[5] !== 8'h01) begin n_errors++; $display("FAIL basic_k192: got %h expected 01", ch0[5]); end
        if (ch0[6] !== 8'h80 || sy[6] !== 1'b1) begin n_errors++; $display("FAIL basic_wrap: got %h/%b expected 80/1", ch0[6], sy[6]); end
        if (ch0[7] !== 8'hFE) begin n_errors++; $display("FAIL basic_k64b: got %h expected fe", ch0[7]); end
    endtask

    task automatic test_retune();
        int wait_cnt;
        wait_cnt = 0;
        cycle(1, 1, 'h2000, 'hFF);
        n_checks++;
        if (cfg_if.cfg_ready !== 1'b0) begin n_errors++; $display("FAIL retune_busy: got %b expected 0", cfg_if.cfg_ready); end
        for (int j = 0; j < 24; j++) begin
            cycle(1, 0, 0, 0);
            if (wait_cnt == j && cfg_if.cfg_ready !== 1'b1) wait_cnt++;
        end
        n_checks++;
        if (wait_cnt < 1 || wait_cnt > 4) begin n_errors++; $display("FAIL retune_wrap_wait: got %0d expected 1..4", wait_cnt); end
    endtask

    task automatic test_amp_zero();
        cycle(1, 1, 'h2000, 'h00);
        for (int j = 0; j < 16; j++) cycle(1, 0, 0, 0);
        n_checks++;
        if (out_data !== mid_all || out_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL amp_zero: got %h/%b expected %h/1", out_data, out_valid, mid_all);
        end
    endtask

    task automatic test_stop_pending();
        logic vl [3];
        cycle(1, 1, 'h1000, 'hFF);
        cycle(0, 0, 0, 0);
        vl[0] = out_valid;
        cycle(0, 0, 0, 0);
        vl[1] = out_valid;
        cycle(0, 0, 0, 0);
        vl[2] = out_valid;
        n_checks++;
        if (vl[0] !== 1'b1 || vl[1] !== 1'b1 || vl[2] !== 1'b0) begin
            n_errors++;
            $display("FAIL stop_valid_fall: got %b%b%b expected 110", vl[0], vl[1], vl[2]);
        end
        for (int j = 0; j < 3; j++) cycle(1, 0, 0, 0);
        n_checks++;
        if (out_data[OUT_W-1:0] !== 8'h80 || sync !== 1'b1 || out_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL restart: got %h/%b/%b expected 80/1/1", out_data[OUT_W-1:0], sync, out_valid);
        end
        for (int j = 0; j < 20; j++) cycle(1, 0, 0, 0);
    endtask

    task automatic test_ftw_zero();
        int n_sync;
        n_sync = 0;
        cycle(0, 1, 0, 'hC0);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);
        for (int j = 0; j < 12; j++) begin
            cycle(1, 0, 0, 0);
            if (sync === 1'b1) n_sync++;
        end
        n_checks++;
        if (n_sync != 1 || out_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL ftw_zero: got syncs=%0d valid=%b expected 1/1", n_sync, out_valid);
        end
    endtask

    task automatic test_async_reset();
        cycle(1, 0, 0, 0);
        cycle(1, 1, 'h3000, 'h40);
        cycle(1, 0, 0, 0);
        #3 rst_n = 1'b0;
        #1;
        n_checks += 4;
        if (out_data !== mid_all) begin n_errors++; $display("FAIL async_data: got %h expected %h", out_data, mid_all); end
        if (out_valid !== 1'b0) begin n_errors++; $display("FAIL async_valid: got %b expected 0", out_valid); end
        if (sync !== 1'b0) begin n_errors++; $display("FAIL async_sync: got %b expected 0", sync); end
        if (cfg_if.cfg_ready !== 1'b1) begin n_errors++; $display("FAIL async_ready: got %b expected 1", cfg_if.cfg_ready); end
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int j = 0; j < 10; j++) cycle(1, 0, 0, 0);
    endtask

    task automatic test_random();
        int f;
        for (int j = 0; j < 400; j++) begin
            f = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255))
                                            : int'($urandom_range(0, (1 << ACC_W) - 1));
            cycle($urandom_range(0, 19) != 0, $urandom_range(0, 5) == 0, f,
                  int'($urandom_range(0, (1 << AMP_W) - 1)));
        end
    endtask

    initial begin
        mid_all = {N_CH{OUT_W'(MID)}};
        test_reset();
        test_basic();
        test_retune();
        test_amp_zero();
        test_stop_pending();
        test_ftw_zero();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/multiphase_sine_dds.md
MULTIPHASE_SINE_DDS -- requirements
Module: multiphase_sine_dds

Interface
REQ-001 SHALL have parameter N_CH, default 3, number of output phases (1..8).
REQ-002 SHALL have parameter OUT_W, default 8, sample width per channel (unsigned offset-binary).
REQ-003 SHALL have parameter ACC_W, default 16, phase accumulator width.
REQ-004 SHALL have parameter LUT_AW, default 8, sine-table address width (2^LUT_AW entries, full wave).
REQ-005 SHALL have parameter AMP_W, default 8, amplitude-scale width.
REQ-006 SHALL use a single clock and an asynchronous, active-low reset; the ports are named clk and rst_n.
REQ-007 SHALL have port clk, input, 1, sole clock; all logic on its rising edge.
REQ-008 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-009 SHALL have port en, input, 1, 1 = run, 0 = stop.
REQ-010 SHALL have port cfg_valid, input, 1, configuration offer.
REQ-011 SHALL have port cfg_ready, output, 1, configuration accepted when it and cfg_valid are both 1.
REQ-012 SHALL have port cfg_ftw, input, ACC_W, frequency tuning word.
REQ-013 SHALL have port cfg_amp, input, AMP_W, amplitude scale (gain = cfg_amp/2^AMP_W).
REQ-014 SHALL have port out_data, output, N_CH*OUT_W, channel i occupies bits [i*OUT_W +: OUT_W].
REQ-015 SHALL have port out_valid, output, 1, out_data holds a valid sample.
REQ-016 SHALL have port sync, output, 1, one-cycle pulse marking the start of a channel-0 period.

Function
REQ-017 SHALL contain an internal ROM: LUT[k] = round((2^(OUT_W-1)-1)*sin(2*pi*k/2^LUT_AW)) + 2^(OUT_W-1).
REQ-018 SHALL use a three-state FSM: STOP, RUN, PEND.
REQ-019 STOP: acc = 0, frozen; cfg_ready = 1; an accepted cfg loads active ftw/amp on the next cycle; en = 1 -> RUN.
REQ-020 RUN: acc <= (acc + ftw) mod 2^ACC_W every cycle; cfg_ready = 1; an accepted cfg is latched into a shadow register -> PEND.
REQ-021 PEND: cfg_ready = 0; acc keeps advancing with the old ftw; on the cycle the add overflows (carry out of ACC_W), the shadow is copied to active ftw/amp so that the next increment uses the new ftw -> RUN.
REQ-022 en = 0 in RUN or PEND SHALL cause STOP on the next edge with acc = 0; a pending shadow SHALL be applied at that same edge.
REQ-023 Channel i phase SHALL be (acc + i*floor(2^ACC_W/N_CH)) mod 2^ACC_W; the LUT index is its top LUT_AW bits.
REQ-024 Scaling SHALL be s = LUT - mid (signed), y = mid + ((s*amp) arithmetic-shift-right AMP_W), where mid = 2^(OUT_W-1) and the shift floors toward minus infinity; no saturation is needed.
REQ-025 Pipeline SHALL be: acc (stage 0) -> registered LUT read (stage 1) -> registered scaled out_data (stage 2); latency is 2 cycles from acc to out_data.
REQ-026 out_valid SHALL be the stage-0 valid (state != STOP) delayed 2 cycles.
REQ-027 sync SHALL be 1 with the sample whose stage-0 value was the first after an overflow, or the first after STOP->RUN; it is delayed identically to the data.
REQ-028 ftw = 0 in RUN SHALL hold a constant output with out_valid = 1 and no sync after the first sample.
REQ-029 The data presented while out_valid = 0 SHALL be mid on every channel.

Reset
REQ-030 rst_n = 0 SHALL immediately force: state STOP, acc 0, active ftw 0, amp 2^AMP_W-1, shadow cleared, pipeline valids 0, out_data mid on all channels, out_valid 0, sync 0, and cfg_ready 1 once released.
REQ-031 Reset asserted mid-operation SHALL discard any pending configuration.

Verification (defaults: N_CH=3, OUT_W=8, ACC_W=16, LUT_AW=8, AMP_W=8)
REQ-032 Reset release -> out_data = 0x808080, out_valid = 0, sync = 0, cfg_ready = 1.
REQ-033 STOP, cfg ftw = 0x4000 amp = 0xFF, then en = 1 -> out_valid rises 2 cycles after RUN entry; ch0 repeats 0x80, 0xFE, 0x80, 0x01; sync = 1 on each 0x80 at k = 0; ch1/ch2 LUT indices offset by 85/170.
REQ-034 RUN with ftw = 0x4000, cfg ftw = 0x2000 offered mid-period -> cfg_ready = 0 until wrap; old 4-sample pattern completes; then 8-sample period; no phase discontinuity.
REQ-035 cfg amp = 0x00 -> after it takes effect, all channels = 0x80 with out_valid = 1.
REQ-036 en dropped mid-run with a pending cfg -> STOP next edge, out_valid falls 2 cycles later, the new ftw is active on re-enable, and ch0 restarts at 0x80 with sync = 1.
REQ-037 rst_n pulsed low asynchronously between edges during RUN -> outputs reach reset values before the next clk edge.
